hpdcache_mshr_tgt: RTL and testbench

- Next-generation miss status holding register for the HPDcache, built from flip-flops.
- Fully associative, with MSHR_ENTRIES entries. Each entry carries a list of up to MSHR_TARGETS requests, so secondary misses to an in-flight line are merged rather than stalled.
- On refill completion, a replay FSM pops the merged targets one per handshake toward the refill/response path, then frees the entry.

---
 rtl/hpdcache_mshr_tgt_pkg.sv | 31 +++
 rtl/hpdcache_mshr_tgt_list.sv | 45 ++++
 rtl/hpdcache_mshr_tgt.sv | 227 ++++++++++++++++++++++
 tb/tb_hpdcache_mshr_tgt.sv | 345 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hpdcache_mshr_tgt_pkg.sv
// Shared types and helpers for the HPDcache target-list MSHR.
// Top-level optional statistics are enabled with HPDCACHE_MSHR_TGT_STATS_EN.
package hpdcache_mshr_tgt_pkg;

  localparam int unsigned HPDCACHE_MSHR_TID_W  = 6;
  localparam int unsigned HPDCACHE_MSHR_SID_W  = 3;
  localparam int unsigned HPDCACHE_MSHR_WORD_W = 3;

  typedef struct packed {
    logic [HPDCACHE_MSHR_TID_W-1:0]  req_id;
    logic [HPDCACHE_MSHR_SID_W-1:0]  src_id;
    logic [HPDCACHE_MSHR_WORD_W-1:0] word;
    logic                            need_rsp;
  } hpdcache_mshr_tgt_t;

  typedef enum logic {
    IDLE,
    REPLAY
  } hpdcache_mshr_rpl_fsm_e;

  // Index of the lowest set bit; returns 0 when no bit is set.
  function automatic logic [4:0] hpdcache_prio_enc(input logic [31:0] vec);
    logic [4:0] idx;
    idx = '0;
    for (int i = 31; i >= 0; i--) begin
      if (vec[i]) idx = 5'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/hpdcache_mshr_tgt_list.sv
// Target list of one MSHR entry: ordered push, indexed read, clear on free.
module hpdcache_mshr_tgt_list
  import hpdcache_mshr_tgt_pkg::*;
#(
  parameter int unsigned MSHR_TARGETS = 4,
  localparam int unsigned CNT_W = $clog2(MSHR_TARGETS + 1),
  localparam int unsigned IDX_W = (MSHR_TARGETS > 1) ? $clog2(MSHR_TARGETS) : 1
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               push_i,
  input  hpdcache_mshr_tgt_t push_tgt_i,
  input  logic               clear_i,
  input  logic [IDX_W-1:0]   rd_idx_i,
  output hpdcache_mshr_tgt_t rd_tgt_o,
  output logic [CNT_W-1:0]   count_o,
  output logic               full_o
);

  hpdcache_mshr_tgt_t tgt_q [MSHR_TARGETS];
  logic [CNT_W-1:0]   count_q, count_d;

  assign full_o   = (count_q == CNT_W'(MSHR_TARGETS));
  assign count_o  = count_q;
  assign rd_tgt_o = tgt_q[rd_idx_i];

  // NOTE: every variable assigned in always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    count_d = count_q;
    if (clear_i)                count_d = '0;
    else if (push_i && !full_o) count_d = count_q + CNT_W'(1);
  end

  // NOTE: sequential state is updated with non-blocking assignments only.
  always_ff @(posedge clk_i) begin
    if (rst_i) count_q <= '0;
    else       count_q <= count_d;
  end

  // NOTE: target storage is deliberately not reset; count_q alone says which slots hold data.
  always_ff @(posedge clk_i) begin
    if (push_i && !full_o) tgt_q[count_q[IDX_W-1:0]] <= push_tgt_i;
  end

endmodule

// File: rtl/hpdcache_mshr_tgt.sv
// Fully associative flip-flop MSHR with per-entry merged target lists and a replay FSM.
// Define HPDCACHE_MSHR_TGT_STATS_EN to add saturating alloc/merge/merge-reject counters.
module hpdcache_mshr_tgt
  import hpdcache_mshr_tgt_pkg::*;
#(
  parameter int unsigned MSHR_ENTRIES = 8,
  parameter int unsigned MSHR_TARGETS = 4,
  parameter int unsigned NLINE_WIDTH  = 40,
  parameter int unsigned TID_WIDTH    = HPDCACHE_MSHR_TID_W,
  parameter int unsigned SID_WIDTH    = HPDCACHE_MSHR_SID_W,
  parameter int unsigned WORD_WIDTH   = HPDCACHE_MSHR_WORD_W,
  parameter int unsigned WAY_WIDTH    = 2,
  localparam int unsigned ID_W = $clog2(MSHR_ENTRIES)
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  output logic                   empty_o,
  output logic                   full_o,
  input  logic                   check_i,
  input  logic [NLINE_WIDTH-1:0] check_nline_i,
  output logic                   hit_o,
  output logic [ID_W-1:0]        hit_id_o,
  output logic                   hit_tgt_full_o,
  input  logic                   alloc_i,
  input  logic [NLINE_WIDTH-1:0] alloc_nline_i,
  input  logic [WAY_WIDTH-1:0]   alloc_victim_way_i,
  input  logic [TID_WIDTH-1:0]   alloc_req_id_i,
  input  logic [SID_WIDTH-1:0]   alloc_src_id_i,
  input  logic [WORD_WIDTH-1:0]  alloc_word_i,
  input  logic                   alloc_need_rsp_i,
  output logic                   alloc_ready_o,
  output logic [ID_W-1:0]        alloc_id_o,
  input  logic                   merge_i,
  input  logic [ID_W-1:0]        merge_id_i,
  input  logic [TID_WIDTH-1:0]   merge_req_id_i,
  input  logic [SID_WIDTH-1:0]   merge_src_id_i,
  input  logic [WORD_WIDTH-1:0]  merge_word_i,
  input  logic                   merge_need_rsp_i,
  output logic                   merge_ready_o,
  input  logic                   ack_i,
  input  logic [ID_W-1:0]        ack_id_i,
  output logic                   ack_ready_o,
  output logic                   rpl_valid_o,
  input  logic                   rpl_ready_i,
  output logic [NLINE_WIDTH-1:0] rpl_nline_o,
  output logic [WAY_WIDTH-1:0]   rpl_way_o,
  output logic [TID_WIDTH-1:0]   rpl_req_id_o,
  output logic [SID_WIDTH-1:0]   rpl_src_id_o,
  output logic [WORD_WIDTH-1:0]  rpl_word_o,
  output logic                   rpl_need_rsp_o,
  output logic                   rpl_last_o
`ifdef HPDCACHE_MSHR_TGT_STATS_EN
  ,
  output logic [31:0]            stat_alloc_o,
  output logic [31:0]            stat_merge_o,
  output logic [31:0]            stat_merge_rej_o
`endif
);

  localparam int unsigned CNT_W = $clog2(MSHR_TARGETS + 1);
  localparam int unsigned IDX_W = (MSHR_TARGETS > 1) ? $clog2(MSHR_TARGETS) : 1;

  logic [MSHR_ENTRIES-1:0] valid_q, valid_d;
  logic [NLINE_WIDTH-1:0]  nline_q [MSHR_ENTRIES];
  logic [WAY_WIDTH-1:0]    way_q   [MSHR_ENTRIES];

  hpdcache_mshr_rpl_fsm_e  state_q, state_d;
  logic [ID_W-1:0]         rpl_id_q, rpl_id_d;
  logic [IDX_W-1:0]        idx_q, idx_d;

  hpdcache_mshr_tgt_t      list_rd_tgt [MSHR_ENTRIES];
  logic [CNT_W-1:0]        list_cnt    [MSHR_ENTRIES];
  logic [MSHR_ENTRIES-1:0] list_full;
  logic [MSHR_ENTRIES-1:0] replaying;
  logic [MSHR_ENTRIES-1:0] free_vec;

  hpdcache_mshr_tgt_t      alloc_tgt, merge_tgt, rpl_tgt;
  logic                    alloc_fire, merge_fire, rpl_done, rpl_last;
  logic                    hit_any;
  logic [ID_W-1:0]         hit_id;

  assign alloc_tgt = {alloc_req_id_i, alloc_src_id_i, alloc_word_i, alloc_need_rsp_i};
  assign merge_tgt = {merge_req_id_i, merge_src_id_i, merge_word_i, merge_need_rsp_i};

  assign free_vec      = ~valid_q;
  assign empty_o       = ~|valid_q;
  assign full_o        = &valid_q;
  assign alloc_ready_o = ~full_o;
  assign alloc_id_o    = ID_W'(hpdcache_prio_enc(32'(free_vec)));

  always_comb begin
    replaying = '0;
    if (state_q == REPLAY) replaying[rpl_id_q] = 1'b1;
  end

  assign merge_ready_o = valid_q[merge_id_i] & ~replaying[merge_id_i] & ~list_full[merge_id_i];
  assign alloc_fire    = alloc_i & alloc_ready_o;
  assign merge_fire    = merge_i & merge_ready_o;

  // Descending scan so the lowest matching index wins.
  always_comb begin
    hit_any = 1'b0;
    hit_id  = '0;
    for (int i = MSHR_ENTRIES - 1; i >= 0; i--) begin
      if (valid_q[i] && !replaying[i] && (nline_q[i] == check_nline_i)) begin
        hit_any = 1'b1;
        hit_id  = ID_W'(i);
      end
    end
  end

  assign hit_o          = check_i & hit_any;
  assign hit_id_o       = hit_id;
  assign hit_tgt_full_o = hit_o & list_full[hit_id];

  for (genvar g = 0; g < MSHR_ENTRIES; g++) begin : g_entry
    logic alloc_here, merge_here;
    assign alloc_here = alloc_fire && (alloc_id_o == ID_W'(g));
    assign merge_here = merge_fire && (merge_id_i == ID_W'(g));

    hpdcache_mshr_tgt_list #(.MSHR_TARGETS(MSHR_TARGETS)) u_list (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .push_i     (alloc_here | merge_here),
      .push_tgt_i (alloc_here ? alloc_tgt : merge_tgt),
      .clear_i    (rpl_done && (rpl_id_q == ID_W'(g))),
      .rd_idx_i   (idx_q),
      .rd_tgt_o   (list_rd_tgt[g]),
      .count_o    (list_cnt[g]),
      .full_o     (list_full[g])
    );
  end

  always_comb begin
    valid_d = valid_q;
    if (alloc_fire) valid_d[alloc_id_o] = 1'b1;
    if (rpl_done)   valid_d[rpl_id_q]   = 1'b0;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) valid_q <= '0;
    else       valid_q <= valid_d;
  end

  always_ff @(posedge clk_i) begin
    if (alloc_fire) begin
      nline_q[alloc_id_o] <= alloc_nline_i;
      way_q[alloc_id_o]   <= alloc_victim_way_i;
    end
  end

  assign rpl_tgt        = list_rd_tgt[rpl_id_q];
  assign rpl_last       = (CNT_W'(idx_q) == (list_cnt[rpl_id_q] - CNT_W'(1)));
  assign ack_ready_o    = (state_q == IDLE);
  assign rpl_valid_o    = (state_q == REPLAY);
  assign rpl_last_o     = rpl_valid_o & rpl_last;
  assign rpl_done       = rpl_valid_o & rpl_ready_i & rpl_last;
  assign rpl_nline_o    = nline_q[rpl_id_q];
  assign rpl_way_o      = way_q[rpl_id_q];
  assign rpl_req_id_o   = rpl_tgt.req_id;
  assign rpl_src_id_o   = rpl_tgt.src_id;
  assign rpl_word_o     = rpl_tgt.word;
  assign rpl_need_rsp_o = rpl_tgt.need_rsp;

  always_comb begin
    state_d  = state_q;
    rpl_id_d = rpl_id_q;
    idx_d    = idx_q;
    unique case (state_q)
      IDLE: begin
        if (ack_i) begin
          state_d  = REPLAY;
          rpl_id_d = ack_id_i;
          idx_d    = '0;
        end
      end
      REPLAY: begin
        if (rpl_ready_i) begin
          if (rpl_last) state_d = IDLE;
          else          idx_d   = idx_q + IDX_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      rpl_id_q <= '0;
      idx_q    <= '0;
    end else begin
      state_q  <= state_d;
      rpl_id_q <= rpl_id_d;
      idx_q    <= idx_d;
    end
  end

`ifdef HPDCACHE_MSHR_TGT_STATS_EN
  logic [31:0] stat_alloc_q, stat_merge_q, stat_merge_rej_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stat_alloc_q     <= '0;
      stat_merge_q     <= '0;
      stat_merge_rej_q <= '0;
    end else begin
      if (alloc_fire && (stat_alloc_q != '1))  stat_alloc_q <= stat_alloc_q + 32'd1;
      if (merge_fire && (stat_merge_q != '1))  stat_merge_q <= stat_merge_q + 32'd1;
      if (merge_i && !merge_ready_o && (stat_merge_rej_q != '1))
        stat_merge_rej_q <= stat_merge_rej_q + 32'd1;
    end
  end

  assign stat_alloc_o     = stat_alloc_q;
  assign stat_merge_o     = stat_merge_q;
  assign stat_merge_rej_o = stat_merge_rej_q;
`endif

  a_alloc_not_full: assert property (@(posedge clk_i) disable iff (rst_i)
    alloc_i |-> !full_o);
  a_merge_not_alloc_entry: assert property (@(posedge clk_i) disable iff (rst_i)
    !(alloc_fire && merge_i && (merge_id_i == alloc_id_o)));
  a_ack_valid_entry: assert property (@(posedge clk_i) disable iff (rst_i)
    (ack_i && ack_ready_o) |-> valid_q[ack_id_i]);

endmodule

// File: tb/tb_hpdcache_mshr_tgt.sv
// Self-checking bench for hpdcache_mshr_tgt: model-driven scoreboard for replays plus a lookup vector table.
module tb_hpdcache_mshr_tgt;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        empty_o, full_o;
  logic        check_i;
  logic [39:0] check_nline_i;
  logic        hit_o;
  logic [2:0]  hit_id_o;
  logic        hit_tgt_full_o;
  logic        alloc_i;
  logic [39:0] alloc_nline_i;
  logic [1:0]  alloc_victim_way_i;
  logic [5:0]  alloc_req_id_i;
  logic [2:0]  alloc_src_id_i;
  logic [2:0]  alloc_word_i;
  logic        alloc_need_rsp_i;
  logic        alloc_ready_o;
  logic [2:0]  alloc_id_o;
  logic        merge_i;
  logic [2:0]  merge_id_i;
  logic [5:0]  merge_req_id_i;
  logic [2:0]  merge_src_id_i;
  logic [2:0]  merge_word_i;
  logic        merge_need_rsp_i;
  logic        merge_ready_o;
  logic        ack_i;
  logic [2:0]  ack_id_i;
  logic        ack_ready_o;
  logic        rpl_valid_o;
  logic        rpl_ready_i;
  logic [39:0] rpl_nline_o;
  logic [1:0]  rpl_way_o;
  logic [5:0]  rpl_req_id_o;
  logic [2:0]  rpl_src_id_o;
  logic [2:0]  rpl_word_o;
  logic        rpl_need_rsp_o;
  logic        rpl_last_o;
`ifdef HPDCACHE_MSHR_TGT_STATS_EN
  logic [31:0] stat_alloc_o, stat_merge_o, stat_merge_rej_o;
`endif

  hpdcache_mshr_tgt dut (
    .clk_i(clk_i), .rst_i(rst_i), .empty_o(empty_o), .full_o(full_o),
    .check_i(check_i), .check_nline_i(check_nline_i), .hit_o(hit_o),
    .hit_id_o(hit_id_o), .hit_tgt_full_o(hit_tgt_full_o),
    .alloc_i(alloc_i), .alloc_nline_i(alloc_nline_i), .alloc_victim_way_i(alloc_victim_way_i),
    .alloc_req_id_i(alloc_req_id_i), .alloc_src_id_i(alloc_src_id_i),
    .alloc_word_i(alloc_word_i), .alloc_need_rsp_i(alloc_need_rsp_i),
    .alloc_ready_o(alloc_ready_o), .alloc_id_o(alloc_id_o),
    .merge_i(merge_i), .merge_id_i(merge_id_i), .merge_req_id_i(merge_req_id_i),
    .merge_src_id_i(merge_src_id_i), .merge_word_i(merge_word_i),
    .merge_need_rsp_i(merge_need_rsp_i), .merge_ready_o(merge_ready_o),
    .ack_i(ack_i), .ack_id_i(ack_id_i), .ack_ready_o(ack_ready_o),
    .rpl_valid_o(rpl_valid_o), .rpl_ready_i(rpl_ready_i), .rpl_nline_o(rpl_nline_o),
    .rpl_way_o(rpl_way_o), .rpl_req_id_o(rpl_req_id_o), .rpl_src_id_o(rpl_src_id_o),
    .rpl_word_o(rpl_word_o), .rpl_need_rsp_o(rpl_need_rsp_o), .rpl_last_o(rpl_last_o)
`ifdef HPDCACHE_MSHR_TGT_STATS_EN
    ,
    .stat_alloc_o(stat_alloc_o), .stat_merge_o(stat_merge_o), .stat_merge_rej_o(stat_merge_rej_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [5:0] tid;
    logic [2:0] sid;
    logic [2:0] word;
    logic       need;
  } tgt_rec_t;

  typedef struct {
    logic [39:0] nline;
    logic        exp_hit;
    logic [2:0]  exp_id;
    logic        exp_tfull;
  } chk_vec_t;

  int          n_checks = 0;
  int          n_err    = 0;

  bit          m_valid [8];
  logic [39:0] m_nline [8];
  logic [1:0]  m_way   [8];
  tgt_rec_t    m_tgt   [8][$];
  tgt_rec_t    exp_q   [$];
  bit          m_rpl_active = 1'b0;
  int          m_rpl_id     = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  function automatic tgt_rec_t mk_tgt(input logic [5:0] tid);
    tgt_rec_t t;
    t.tid  = tid;
    t.sid  = tid[2:0] ^ 3'b101;
    t.word = tid[4:2];
    t.need = tid[0];
    return t;
  endfunction

  function automatic int model_free();
    for (int i = 0; i < 8; i++) if (!m_valid[i]) return i;
    return 0;
  endfunction

  function automatic bit model_full();
    for (int i = 0; i < 8; i++) if (!m_valid[i]) return 1'b0;
    return 1'b1;
  endfunction

  function automatic bit model_empty();
    for (int i = 0; i < 8; i++) if (m_valid[i]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic do_alloc(input logic [39:0] nline, input logic [1:0] way, input logic [5:0] tid);
    int       exp_id;
    tgt_rec_t t;
    exp_id = model_free();
    t      = mk_tgt(tid);
    alloc_i = 1'b1; alloc_nline_i = nline; alloc_victim_way_i = way;
    alloc_req_id_i = t.tid; alloc_src_id_i = t.sid; alloc_word_i = t.word; alloc_need_rsp_i = t.need;
    #1;
    check("alloc_ready", alloc_ready_o, 1);
    check("alloc_id", alloc_id_o, exp_id);
    tick();
    alloc_i = 1'b0;
    m_valid[exp_id] = 1'b1;
    m_nline[exp_id] = nline;
    m_way[exp_id]   = way;
    m_tgt[exp_id].delete();
    m_tgt[exp_id].push_back(t);
  endtask

  task automatic do_merge(input int id, input logic [5:0] tid);
    bit       exp_rdy;
    tgt_rec_t t;
    t       = mk_tgt(tid);
    exp_rdy = m_valid[id] && (m_tgt[id].size() < 4) && !(m_rpl_active && m_rpl_id == id);
    merge_i = 1'b1; merge_id_i = 3'(id);
    merge_req_id_i = t.tid; merge_src_id_i = t.sid; merge_word_i = t.word; merge_need_rsp_i = t.need;
    #1;
    check("merge_ready", merge_ready_o, exp_rdy);
    tick();
    merge_i = 1'b0;
    if (exp_rdy) m_tgt[id].push_back(t);
  endtask

  task automatic start_replay(input int id);
    check("ack_ready_idle", ack_ready_o, 1);
    ack_i = 1'b1; ack_id_i = 3'(id);
    exp_q = m_tgt[id];
    m_rpl_active = 1'b1;
    m_rpl_id     = id;
    tick();
    ack_i = 1'b0;
  endtask

  // pat[k] is rpl_ready_i for the k-th replay cycle; ready stays high after plen cycles.
  task automatic drain_replay(input int id, input logic [7:0] pat, input int plen);
    bit done;
    done = 1'b0;
    for (int k = 0; k < 40 && !done; k++) begin
      rpl_ready_i = (k < plen) ? pat[k] : 1'b1;
      #1;
      check("rpl_valid", rpl_valid_o, 1);
      if (rpl_valid_o && exp_q.size() > 0) begin
        check("rpl_req_id", rpl_req_id_o, exp_q[0].tid);
        check("rpl_src_id", rpl_src_id_o, exp_q[0].sid);
        check("rpl_word", rpl_word_o, exp_q[0].word);
        check("rpl_need_rsp", rpl_need_rsp_o, exp_q[0].need);
        check("rpl_last", rpl_last_o, exp_q.size() == 1);
        check("rpl_nline", rpl_nline_o, m_nline[id]);
        check("rpl_way", rpl_way_o, m_way[id]);
        check("full_during_rpl", full_o, model_full());
        check("ack_ready_busy", ack_ready_o, 0);
        if (rpl_ready_i) begin
          void'(exp_q.pop_front());
          if (exp_q.size() == 0) done = 1'b1;
        end
      end
      tick();
    end
    rpl_ready_i = 1'b0;
    check("rpl_complete", done, 1);
    m_valid[id] = 1'b0;
    m_tgt[id].delete();
    m_rpl_active = 1'b0;
    check("rpl_idle_after", rpl_valid_o, 0);
    check("ack_ready_after", ack_ready_o, 1);
    check("empty_after", empty_o, model_empty());
  endtask

  chk_vec_t vecs [10];

  initial begin
    rst_i = 1'b1; check_i = 1'b0; check_nline_i = '0;
    alloc_i = 1'b0; alloc_nline_i = '0; alloc_victim_way_i = '0;
    alloc_req_id_i = '0; alloc_src_id_i = '0; alloc_word_i = '0; alloc_need_rsp_i = 1'b0;
    merge_i = 1'b0; merge_id_i = '0; merge_req_id_i = '0; merge_src_id_i = '0;
    merge_word_i = '0; merge_need_rsp_i = 1'b0;
    ack_i = 1'b0; ack_id_i = '0; rpl_ready_i = 1'b0;
    for (int i = 0; i < 8; i++) m_valid[i] = 1'b0;
    tick(); tick();
    rst_i = 1'b0;
    check_i = 1'b1; check_nline_i = 40'h100;
    #1;
    check("rst_empty", empty_o, 1);
    check("rst_full", full_o, 0);
    check("rst_hit", hit_o, 0);
    check("rst_rpl_valid", rpl_valid_o, 0);
    check("rst_ack_ready", ack_ready_o, 1);
    check("rst_alloc_id", alloc_id_o, 0);

    // First allocation and lookup.
    do_alloc(40'h100, 2'd1, 6'd5);
    check_nline_i = 40'h100;
    #1;
    check("hit_100", hit_o, 1);
    check("hit_id_100", hit_id_o, 0);
    check("empty_after_alloc", empty_o, 0);
    check("tgt_full_1", hit_tgt_full_o, 0);

    // Merge up to the target limit, then one refused merge.
    do_merge(0, 6'd6);
    do_merge(0, 6'd7);
    do_merge(0, 6'd8);
    merge_id_i = 3'd0;
    #1;
    check("tgt_full_4", hit_tgt_full_o, 1);
    check("merge_ready_full", merge_ready_o, 0);
    do_merge(0, 6'd9);
`ifdef HPDCACHE_MSHR_TGT_STATS_EN
    check("stat_alloc", stat_alloc_o, 1);
    check("stat_merge", stat_merge_o, 3);
    check("stat_merge_rej", stat_merge_rej_o, 1);
`endif

    // Replay entry 0 with back-pressure on the second target.
    start_replay(0);
    drain_replay(0, 8'b0001_1101, 5);
    check("empty_after_rpl0", empty_o, 1);

    // Fill every entry; entry 2 gets 3 targets, entry 5 gets 4.
    for (int i = 0; i < 8; i++) do_alloc(40'h200 + 40'(i), 2'(i), 6'(10 + i));
    do_merge(2, 6'd30);
    do_merge(2, 6'd31);
    do_merge(5, 6'd40);
    do_merge(5, 6'd41);
    do_merge(5, 6'd42);
    #1;
    check("full_all", full_o, 1);
    check("alloc_ready_full", alloc_ready_o, 0);

    for (int i = 0; i < 8; i++) vecs[i] = '{40'h200 + 40'(i), 1'b1, 3'(i), (i == 5)};
    vecs[8] = '{40'h100, 1'b0, 3'd0, 1'b0};
    vecs[9] = '{40'h2FF, 1'b0, 3'd0, 1'b0};
    for (int v = 0; v < 10; v++) begin
      check_nline_i = vecs[v].nline;
      #1;
      check("vec_hit", hit_o, vecs[v].exp_hit);
      if (vecs[v].exp_hit) begin
        check("vec_hit_id", hit_id_o, vecs[v].exp_id);
        check("vec_tgt_full", hit_tgt_full_o, vecs[v].exp_tfull);
      end
    end

    // Free entry 3; the slot becomes visible only after the freeing edge.
    start_replay(3);
    drain_replay(3, 8'h00, 0);
    check("alloc_id_freed3", alloc_id_o, 3);
    check("full_after_free3", full_o, 0);
    start_replay(4);
    drain_replay(4, 8'h00, 0);
    do_alloc(40'h203, 2'd3, 6'd13);

    // During replay of entry 2: hidden from lookup, merge refused, alloc to entry 4 allowed.
    start_replay(2);
    rpl_ready_i = 1'b0;
    check_nline_i = 40'h202;
    merge_id_i = 3'd2;
    #1;
    check("rpl2_hit", hit_o, 0);
    check("rpl2_merge_ready", merge_ready_o, 0);
    check("rpl2_ack_ready", ack_ready_o, 0);
    check("rpl2_first_tid", rpl_req_id_o, 12);
    do_alloc(40'h204, 2'd0, 6'd20);
    drain_replay(2, 8'h00, 0);
    check_nline_i = 40'h204;
    #1;
    check("hit_204", hit_o, 1);
    check("hit_id_204", hit_id_o, 4);

    // Reset in the middle of a replay.
    start_replay(0);
    rpl_ready_i = 1'b0;
    #1;
    check("pre_rst_rpl_valid", rpl_valid_o, 1);
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    for (int i = 0; i < 8; i++) begin
      m_valid[i] = 1'b0;
      m_tgt[i].delete();
    end
    m_rpl_active = 1'b0;
    #1;
    check("mid_rst_rpl_valid", rpl_valid_o, 0);
    check("mid_rst_empty", empty_o, 1);
    check("mid_rst_ack_ready", ack_ready_o, 1);
    check("mid_rst_alloc_id", alloc_id_o, 0);
`ifdef HPDCACHE_MSHR_TGT_STATS_EN
    check("mid_rst_stat_alloc", stat_alloc_o, 0);
`endif
    tick();
    check("post_rst_rpl_valid", rpl_valid_o, 0);
    do_alloc(40'h300, 2'd2, 6'd50);
    check_nline_i = 40'h300;
    #1;
    check("hit_300", hit_o, 1);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
